// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-port ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned NumRomPorts = 2;
  localparam int unsigned PortIfetch  = 0;
  localparam int unsigned PortLoad    = 1;

  typedef logic [0:0] rom_port_t;

endpackage : rom_arb_pkg

// File: rtl/rom_port_arbiter_if.sv
// Request/response and ROM-side signals of the ROM port arbiter.
interface rom_port_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);

  logic [NumRomPorts-1:0]           req_valid_i;
  logic [NumRomPorts-1:0]           req_ready_o;
  logic [NumRomPorts*AddrWidth-1:0] req_addr_i;
  logic [NumRomPorts-1:0]           resp_valid_o;
  logic [NumRomPorts-1:0]           resp_ready_i;
  logic [NumRomPorts*DataWidth-1:0] resp_data_o;
  logic [NumRomPorts-1:0]           resp_err_o;
  logic [AddrWidth-1:0]             rom_raddr_o;
  logic [DataWidth-1:0]             rom_rdata_i;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_addr_i, resp_ready_i, rom_rdata_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_err_o, rom_raddr_o
  );

  // Requester / ROM side.
  modport master (
    output req_valid_i, req_addr_i, resp_ready_i, rom_rdata_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o, rom_raddr_o
  );

endinterface : rom_port_arbiter_if

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; remembers the last granted port.
module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumRomPorts-1:0] eligible_i,
  output logic [NumRomPorts-1:0] grant_o,
  output rom_port_t              grant_idx_o
);

  rom_port_t rr_last_q, rr_last_d;

  // Tie goes to the port that did not win last; idle selects port 0.
  always_comb begin
    grant_idx_o = rom_port_t'(PortIfetch);
    grant_o     = '0;
    rr_last_d   = rr_last_q;
    if (eligible_i[PortIfetch] && eligible_i[PortLoad]) begin
      grant_idx_o = ~rr_last_q;
    end else if (eligible_i[PortLoad]) begin
      grant_idx_o = rom_port_t'(PortLoad);
    end
    if (|eligible_i) begin
      grant_o[grant_idx_o] = 1'b1;
      rr_last_d            = grant_idx_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_q <= rom_port_t'(PortLoad);
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule : rr_arbiter2

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM read port between ifetch and load requesters,
// returning each lookup through a per-port response register one cycle later.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned RomSizeBytes = 4096,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rom_port_arbiter_if.slave  bus
);

  localparam int unsigned OffsetWidth = $clog2(DataWidth / 8);
  localparam int unsigned RomAw       = $clog2(RomSizeBytes);

  if ((RomSizeBytes == 0) || ((RomSizeBytes & (RomSizeBytes - 1)) != 0)) begin : g_bad_size
    $fatal(1, "rom_port_arbiter: RomSizeBytes must be a non-zero power of two");
  end
  if ((DataWidth == 0) || ((DataWidth % 8) != 0)) begin : g_bad_data
    $fatal(1, "rom_port_arbiter: DataWidth must be a multiple of 8");
  end
  if (AddrWidth < RomAw) begin : g_bad_addr
    $fatal(1, "rom_port_arbiter: AddrWidth too narrow for RomSizeBytes");
  end

  logic [NumRomPorts-1:0] eligible_c;
  logic [NumRomPorts-1:0] grant_c;
  rom_port_t              grant_idx_c;
  logic [AddrWidth-1:0]   raddr_c;
  logic                   range_err_c;
  logic                   align_err_c;
  logic                   err_c;

  logic [NumRomPorts-1:0] resp_valid_q, resp_valid_d;
  logic [NumRomPorts-1:0] resp_err_q, resp_err_d;
  logic [DataWidth-1:0]   resp_data_q [NumRomPorts];
  logic [DataWidth-1:0]   resp_data_d [NumRomPorts];

  // A port may issue when its response slot is empty or draining this cycle.
  always_comb begin
    eligible_c = '0;
    for (int p = 0; p < NumRomPorts; p++) begin
      eligible_c[p] = !rst_i && bus.req_valid_i[p] &&
                      (!resp_valid_q[p] || bus.resp_ready_i[p]);
    end
  end

  rr_arbiter2 u_rr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .eligible_i (eligible_c),
    .grant_o    (grant_c),
    .grant_idx_o(grant_idx_c)
  );

  assign raddr_c = (grant_idx_c == rom_port_t'(PortLoad))
                 ? bus.req_addr_i[AddrWidth +: AddrWidth]
                 : bus.req_addr_i[0 +: AddrWidth];

  if (AddrWidth > RomAw) begin : g_range
    assign range_err_c = |raddr_c[AddrWidth-1:RomAw];
  end else begin : g_no_range
    assign range_err_c = 1'b0;
  end

  if (OffsetWidth > 0) begin : g_align
    assign align_err_c = |raddr_c[OffsetWidth-1:0];
  end else begin : g_no_align
    assign align_err_c = 1'b0;
  end

  assign err_c = range_err_c || align_err_c;

  // A new grant overwrites the slot; otherwise a handshake empties it.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    for (int p = 0; p < NumRomPorts; p++) begin
      resp_data_d[p] = resp_data_q[p];
      if (grant_c[p]) begin
        resp_valid_d[p] = 1'b1;
        resp_err_d[p]   = err_c;
        resp_data_d[p]  = err_c ? '0 : bus.rom_rdata_i;
      end else if (bus.resp_ready_i[p]) begin
        resp_valid_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      for (int p = 0; p < NumRomPorts; p++) begin
        resp_data_q[p] <= '0;
      end
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      for (int p = 0; p < NumRomPorts; p++) begin
        resp_data_q[p] <= resp_data_d[p];
      end
    end
  end

  assign bus.req_ready_o  = grant_c;
  assign bus.rom_raddr_o  = raddr_c;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_data_o  = {resp_data_q[PortLoad], resp_data_q[PortIfetch]};

endmodule : rom_port_arbiter
